// File: rtl/aer_pkg.sv
// -----------------------------------------------------------------------------
// aer_pkg
// Shared definitions for the AER input arbiter:
//   AER_ADDR_BITS : default AER address width
//   arb_state_t   : arbiter FSM states (IDLE, SEND, HANDOFF)
//   rr_pick_t     : result of a round-robin search (valid flag + index)
//   rr_pick()     : round-robin search over up to 8 request lines
// -----------------------------------------------------------------------------
package aer_pkg;

    localparam int AER_ADDR_BITS = 10;
    localparam int AER_MAX_SRC   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        HANDOFF = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // Returns the first asserted request found searching ptr, ptr+1, ...
    // (mod n_src). Offsets are scanned from the farthest to the nearest so
    // the last hit written is the one closest to the pointer.
    function automatic rr_pick_t rr_pick(
        input logic [7:0] req,
        input logic [2:0] ptr,
        input logic [3:0] n_src
    );
        rr_pick_t   res;
        logic [3:0] cand;
        logic [3:0] wrap;
        logic       hit;
        res = '0;
        for (int k = 7; k >= 0; k--) begin
            cand = {1'b0, ptr} + 4'(k);
            wrap = (cand >= n_src) ? (cand - n_src) : cand;
            hit  = (4'(k) < n_src) && req[wrap[2:0]];
            res  = hit ? rr_pick_t'({1'b1, wrap[2:0]}) : res;
        end
        return res;
    endfunction

endpackage

// File: rtl/aer_sync2.sv
// -----------------------------------------------------------------------------
// aer_sync2
// Two-flop synchronizer for a single-bit level signal crossing into the
// arbiter clock domain. Both flops clear on reset.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input level
//   q     out synchronized level (2 cycles of latency)
// -----------------------------------------------------------------------------
module aer_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/aer_in_arbiter.sv
// -----------------------------------------------------------------------------
// aer_in_arbiter
// Shares the neuron core's single AER input link between N_SRC four-phase
// REQ/ACK event sources. A round-robin pointer selects the next source, the
// granted address is latched and the handshake is relayed to the core. The
// number of forwarded events is counted (wrapping).
//
// Optional build macro AER_ARB_SYNC_EN: when defined, every SRC_REQ bit and
// AEROUT_ACK go through a 2-flop synchronizer before the FSM (request to
// AEROUT_REQ latency 3 cycles instead of 1, ACK/release reaction +2 cycles).
//
// Ports:
//   CLK          in  system clock, rising edge
//   RSTN         in  asynchronous active-low reset
//   ENABLE       in  gates new grants; an in-flight transfer completes
//   SRC_REQ      in  [N_SRC]            per-source request
//   SRC_ADDR     in  [N_SRC*ADDR_BITS]  per-source address, packed
//   SRC_ACK      out [N_SRC]            per-source acknowledge (one-hot/zero)
//   AEROUT_REQ   out request to core
//   AEROUT_ADDR  out [ADDR_BITS]        forwarded address
//   AEROUT_ACK   in  acknowledge from core
//   GRANT_IDX    out [IDX_W]            current/last granted source
//   ARB_BUSY     out high whenever the FSM is not in IDLE
//   EVT_CNT      out [CNT_BITS]         forwarded events since reset
// -----------------------------------------------------------------------------
module aer_in_arbiter
    import aer_pkg::*;
#(
    parameter  int N_SRC     = 2,
    parameter  int ADDR_BITS = AER_ADDR_BITS,
    parameter  int CNT_BITS  = 16,
    localparam int IDX_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       ENABLE,
    input  logic [N_SRC-1:0]           SRC_REQ,
    input  logic [N_SRC*ADDR_BITS-1:0] SRC_ADDR,
    output logic [N_SRC-1:0]           SRC_ACK,
    output logic                       AEROUT_REQ,
    output logic [ADDR_BITS-1:0]       AEROUT_ADDR,
    input  logic                       AEROUT_ACK,
    output logic [IDX_W-1:0]           GRANT_IDX,
    output logic                       ARB_BUSY,
    output logic [CNT_BITS-1:0]        EVT_CNT
);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] req_s;
    logic             ack_s;

`ifdef AER_ARB_SYNC_EN
    for (genvar i = 0; i < N_SRC; i++) begin : g_req_sync
        aer_sync2 u_req_sync (
            .clk   (CLK),
            .rst_n (RSTN),
            .d     (SRC_REQ[i]),
            .q     (req_s[i])
        );
    end

    aer_sync2 u_ack_sync (
        .clk   (CLK),
        .rst_n (RSTN),
        .d     (AEROUT_ACK),
        .q     (ack_s)
    );
`else
    assign req_s = SRC_REQ;
    assign ack_s = AEROUT_ACK;
`endif

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    arb_state_t           state_r;
    arb_state_t           state_nxt_s;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     grant_r;
    logic [ADDR_BITS-1:0] addr_r;
    logic [N_SRC-1:0]     src_ack_r;
    logic                 aerout_req_r;
    logic                 busy_r;
    logic [CNT_BITS-1:0]  cnt_r;

    logic [IDX_W-1:0]     ptr_nxt_s;
    logic [IDX_W-1:0]     grant_nxt_s;
    logic [ADDR_BITS-1:0] addr_nxt_s;
    logic [N_SRC-1:0]     src_ack_nxt_s;
    logic                 aerout_req_nxt_s;
    logic                 busy_nxt_s;
    logic [CNT_BITS-1:0]  cnt_nxt_s;

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    logic [7:0]           req8_s;
    logic [2:0]           ptr3_s;
    rr_pick_t             pick_s;
    logic [ADDR_BITS-1:0] addr_sel_s;
    logic                 req_g_s;

    // Widen the request vector and pointer to the helper's fixed width
    always_comb begin
        req8_s              = 8'd0;
        req8_s[N_SRC-1:0]   = req_s;
        ptr3_s              = 3'(ptr_r);
    end

    assign pick_s     = rr_pick(req8_s, ptr3_s, 4'(N_SRC));
    assign addr_sel_s = SRC_ADDR[32'(pick_s.idx) * ADDR_BITS +: ADDR_BITS];
    // Request line of the source currently holding the grant
    assign req_g_s    = req_s[grant_r];

    // FSM state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (ENABLE && pick_s.valid) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                // A source dropping REQ here is a protocol violation and is
                // ignored: only the core's ACK moves the transfer forward.
                if (ack_s) begin
                    state_nxt_s = HANDOFF;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            HANDOFF: begin
                if (!req_g_s && !ack_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HANDOFF;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM output logic: next values of every registered output
    always_comb begin
        ptr_nxt_s     = ptr_r;
        grant_nxt_s   = grant_r;
        addr_nxt_s    = addr_r;
        cnt_nxt_s     = cnt_r;
        src_ack_nxt_s = '0;
        case (state_r)
            IDLE: begin
                if (state_nxt_s == SEND) begin
                    grant_nxt_s = IDX_W'(pick_s.idx);
                    addr_nxt_s  = addr_sel_s;
                end else begin
                    grant_nxt_s = grant_r;
                    addr_nxt_s  = addr_r;
                end
            end
            SEND: begin
                if (state_nxt_s == HANDOFF) begin
                    cnt_nxt_s = cnt_r + CNT_BITS'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            HANDOFF: begin
                // Pointer moves past the source just served for fairness
                if (state_nxt_s == IDLE) begin
                    ptr_nxt_s = (grant_r == IDX_W'(N_SRC - 1)) ? '0
                                                               : grant_r + IDX_W'(1);
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            default: begin
                ptr_nxt_s = ptr_r;
            end
        endcase

        aerout_req_nxt_s = (state_nxt_s == SEND);
        busy_nxt_s       = (state_nxt_s != IDLE);
        if (state_nxt_s == HANDOFF) begin
            src_ack_nxt_s[grant_nxt_s] = 1'b1;
        end else begin
            src_ack_nxt_s = '0;
        end
    end

    // Output and datapath registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ptr_r        <= '0;
            grant_r      <= '0;
            addr_r       <= '0;
            src_ack_r    <= '0;
            aerout_req_r <= 1'b0;
            busy_r       <= 1'b0;
            cnt_r        <= '0;
        end else begin
            ptr_r        <= ptr_nxt_s;
            grant_r      <= grant_nxt_s;
            addr_r       <= addr_nxt_s;
            src_ack_r    <= src_ack_nxt_s;
            aerout_req_r <= aerout_req_nxt_s;
            busy_r       <= busy_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end
    end

    assign SRC_ACK     = src_ack_r;
    assign AEROUT_REQ  = aerout_req_r;
    assign AEROUT_ADDR = addr_r;
    assign GRANT_IDX   = grant_r;
    assign ARB_BUSY    = busy_r;
    assign EVT_CNT     = cnt_r;

endmodule

// File: doc/aer_in_arbiter.md
Name: aer_in_arbiter

Overview:
- Shares the single AER input link of the neuron core between N_SRC independent AER event sources, for example the pixel encoder and a host/debug spike injector.
- Uses four-phase REQ/ACK on every source port and on the output port.
- Grants sources round-robin, latches the granted address and relays the handshake.
- Sits between the encoders and the core's AERIN port; counts forwarded events for the inference controller.

Parameters:
- N_SRC, 2, number of requesting AER sources (2..8).
- ADDR_BITS, 10, AER address width (IMAGE_SIZE_BITS+2 for 256-pixel images).
- CNT_BITS, 16, width of the forwarded-event counter.

Ports:
- CLK  in  1  system clock, rising-edge.
- RSTN  in  1  asynchronous active-low reset.
- ENABLE  in  1  when low, no new grant is issued; an in-flight transfer completes.
- SRC_REQ  in  N_SRC  per-source four-phase request.
- SRC_ADDR  in  N_SRC*ADDR_BITS  per-source address, packed; source i occupies bits [i*ADDR_BITS +: ADDR_BITS]; stable while SRC_REQ[i]=1.
- SRC_ACK  out  N_SRC  per-source acknowledge; at most one bit high (one-hot or zero).
- AEROUT_REQ  out  1  request to core.
- AEROUT_ADDR  out  ADDR_BITS  forwarded address; stable whenever AEROUT_REQ=1.
- AEROUT_ACK  in  1  acknowledge from core.
- GRANT_IDX  out  $clog2(N_SRC) (min 1)  index of the current/last granted source.
- ARB_BUSY  out  1  high in any state other than IDLE.
- EVT_CNT  out  CNT_BITS  number of events forwarded since reset.

Behaviour:
- Reset (RSTN=0, asynchronous): all outputs 0, state=IDLE, round-robin pointer=0, latched address=0. Reset mid-transfer aborts the transfer silently; no ACK is ever issued for it.
- All outputs are registered.
- State IDLE:
  - If ENABLE=1 and any SRC_REQ bit is 1, pick the first requesting index searching from pointer, then pointer+1, ... mod N_SRC.
  - Latch SRC_ADDR[g] into AEROUT_ADDR, set GRANT_IDX=g, go to SEND.
  - AEROUT_REQ rises on the clock edge after SRC_REQ is sampled high: 1 cycle latency.
- State SEND:
  - AEROUT_REQ=1.
  - On AEROUT_ACK=1: AEROUT_REQ<=0, SRC_ACK[g]<=1, EVT_CNT<=EVT_CNT+1, go to HANDOFF.
- State HANDOFF:
  - Hold SRC_ACK[g]=1.
  - When SRC_REQ[g]=0 and AEROUT_ACK=0 (either order, or both in the same cycle): SRC_ACK[g]<=0, pointer<=(g+1) mod N_SRC, go to IDLE.
- Minimum IDLE->IDLE cycle: 1 (IDLE) + 1 (SEND) + 1 (HANDOFF) cycles plus external handshake delays. A new grant is possible in the cycle after returning to IDLE.
- Simultaneous requests: the round-robin order guarantees fairness. With both sources held high, grants alternate 0,1,0,1.
- Non-granted requests stay pending. Their SRC_ACK stays 0 and their address is not sampled.
- SRC_REQ[g] falling during SEND is a protocol violation: the block ignores it and completes the transfer. The bench flags it with an assertion.
- ENABLE falling during SEND or HANDOFF has no effect until IDLE.
- EVT_CNT wraps modulo 2^CNT_BITS.
- N_SRC=1 degenerates to a registered pass-through; the pointer stays 0.

Optional Feature:
- Macro: AER_ARB_SYNC_EN.
- Defined:
  - Every SRC_REQ bit and AEROUT_ACK pass through 2-flop synchronizers before the FSM, for sources or a core in another clock domain.
  - Request-to-AEROUT_REQ latency is 3 cycles.
  - The ACK/REQ-release reaction in SEND/HANDOFF is delayed by 2 cycles.
  - SRC_ADDR is sampled in the same cycle as the synchronized request; sources must hold it stable while requesting.
- Undefined: inputs are used directly; latencies as in Behaviour.

Decomposition:
- Package aer_pkg:
  - localparam AER_ADDR_BITS=10.
  - typedef enum logic [1:0] {IDLE, SEND, HANDOFF} arb_state_t.
  - Function rr_pick (request vector, pointer -> index, valid).
- Sub-module aer_sync2: a 2-flop synchronizer with async active-low reset, instantiated per input bit under AER_ARB_SYNC_EN.

Test Plan:
- Single event: source 0 raises REQ with ADDR=10'h05A, the core acks after 25 cycles -> AEROUT_REQ high at cycle+1, AEROUT_ADDR=0x05A, SRC_ACK=2'b01 after the ack, EVT_CNT=1, back to IDLE after REQ0 and ACK drop.
- Contention: both sources request continuously, addresses 0x001 and 0x200, 8 events each -> GRANT_IDX sequence 0,1,0,1..., AEROUT_ADDR alternates 0x001/0x200, EVT_CNT=16, SRC_ACK never 2'b11.
- Enable gating: ENABLE=0 while REQ0=1 -> AEROUT_REQ stays 0 for 50 cycles; ENABLE=1 -> AEROUT_REQ rises next cycle. ENABLE dropped during SEND -> transfer completes.
- Reset mid-transfer: assert RSTN=0 in HANDOFF -> all outputs 0 asynchronously, EVT_CNT=0, pointer=0. After release, a pending REQ1 is granted first only if REQ0=0.
- Counter wrap: with CNT_BITS=4, 17 events -> EVT_CNT=1.
- Sync build (AER_ARB_SYNC_EN): single event -> AEROUT_REQ rises 3 cycles after SRC_REQ, addresses identical to the unsynchronized run.
